// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues word reads to instruction memory under a
// credit limit, queues returning {pc, data} pairs for decode, and handles
// redirects by flushing the queue and discarding responses already in flight.
module inst_fetch #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        INST_RDEN,
  output logic [31:0] INST_RADDR,
  input  logic        MEM_WAIT,
  input  logic        INST_RVALID,
  input  logic [31:0] INST_RDATA,
  input  logic        JMP_DO,
  input  logic [31:0] JMP_PC,
  output logic        FETCH_VALID,
  output logic [31:0] FETCH_PC,
  output logic [31:0] FETCH_DATA,
  input  logic        FETCH_READY
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [31:0]   START_PC = RESET_PC & ~32'h3;

  logic          rden_q, rden_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
  logic [31:0]   data_mem_q [QUEUE_DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic          rsp_drop;
  logic [SW-1:0] credit_sum;

  // Handshake decode: a pop or push on a redirect edge is swallowed by the flush.
  always_comb begin
    accept     = rden_q & ~MEM_WAIT;
    rsp_drop   = INST_RVALID & (discard_q != '0);
    push       = INST_RVALID & (discard_q == '0) & ~JMP_DO;
    pop        = (count_q != '0) & FETCH_READY & ~JMP_DO;
    credit_sum = SW'(count_q) + SW'(outst_q) + SW'(accept) - SW'(pop);
  end

  // Next-state logic for request issue, response tracking and queue pointers.
  always_comb begin
    rden_d    = rden_q;
    req_pc_d  = req_pc_q;
    rsp_pc_d  = rsp_pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    case ({accept, INST_RVALID})
      2'b10:   outst_d = outst_q + CNT_ONE;
      2'b01:   outst_d = outst_q - CNT_ONE;
      default: outst_d = outst_q;
    endcase

    if (JMP_DO) begin
      rden_d    = 1'b0;
      req_pc_d  = JMP_PC & ~32'h3;
      rsp_pc_d  = JMP_PC & ~32'h3;
      count_d   = '0;
      rd_ptr_d  = wr_ptr_q;
      discard_d = outst_d;
    end else begin
      rden_d = (credit_sum < SW'(QUEUE_DEPTH));
      if (accept) begin
        req_pc_d = req_pc_q + 32'd4;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rsp_drop) begin
        discard_d = discard_q - CNT_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rden_q    <= 1'b0;
      req_pc_q  <= START_PC;
      rsp_pc_q  <= START_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      rden_q    <= rden_d;
      req_pc_q  <= req_pc_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Queue storage; contents need no reset because the count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      data_mem_q[wr_ptr_q] <= INST_RDATA;
    end
  end

  assign INST_RDEN   = rden_q;
  assign INST_RADDR  = req_pc_q;
  assign FETCH_VALID = (count_q != '0);
  assign FETCH_PC    = FETCH_VALID ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign FETCH_DATA  = FETCH_VALID ? data_mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: an in-order instruction memory model with
// programmable latency answers requests, and each step checks the fetch and
// request outputs against hand-derived values.
module tb_inst_fetch;

  logic        CLK;
  logic        RST;
  logic        INST_RDEN;
  logic [31:0] INST_RADDR;
  logic        MEM_WAIT;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        JMP_DO;
  logic [31:0] JMP_PC;
  logic        FETCH_VALID;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_DATA;
  logic        FETCH_READY;

  int total = 0;
  int bad   = 0;
  int latency = 1;
  int memCycle = 0;
  int acceptsAt8 = 0;
  int base8;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t pend[$];
  req_t newReq;

  inst_fetch #(
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .INST_RDEN  (INST_RDEN),
    .INST_RADDR (INST_RADDR),
    .MEM_WAIT   (MEM_WAIT),
    .INST_RVALID(INST_RVALID),
    .INST_RDATA (INST_RDATA),
    .JMP_DO     (JMP_DO),
    .JMP_PC     (JMP_PC),
    .FETCH_VALID(FETCH_VALID),
    .FETCH_PC   (FETCH_PC),
    .FETCH_DATA (FETCH_DATA),
    .FETCH_READY(FETCH_READY)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: just after each falling edge, present the response due at
  // the coming rising edge, then record the request that edge will accept.
  initial begin
    INST_RVALID = 1'b0;
    INST_RDATA  = 32'h0;
    forever begin
      @(negedge CLK);
      #1;
      memCycle++;
      INST_RVALID = 1'b0;
      INST_RDATA  = 32'h0;
      if (!RST) begin
        pend.delete();
      end else begin
        if (pend.size() > 0 && pend[0].due <= memCycle) begin
          INST_RVALID = 1'b1;
          INST_RDATA  = memWord(pend[0].addr);
          void'(pend.pop_front());
        end
        if (INST_RDEN && !MEM_WAIT) begin
          newReq.addr = INST_RADDR;
          newReq.due  = memCycle + latency;
          pend.push_back(newReq);
          if (INST_RADDR == 32'h8) acceptsAt8++;
        end
      end
    end
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ready, input logic waitV,
                               input logic jmp, input logic [31:0] jpc);
    RST         = rst;
    FETCH_READY = ready;
    MEM_WAIT    = waitV;
    JMP_DO      = jmp;
    JMP_PC      = jpc;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_rden",  INST_RDEN,   32'h0);
    checkOutput("rst_raddr", INST_RADDR,  32'h0);
    checkOutput("rst_valid", FETCH_VALID, 32'h0);
    checkOutput("rst_pc",    FETCH_PC,    32'h0);
    checkOutput("rst_data",  FETCH_DATA,  32'h0);
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, FETCH_VALID, 32'h1);
    checkOutput({tag, "_pc"},    FETCH_PC,    pc);
    checkOutput({tag, "_data"},  FETCH_DATA,  memWord(pc));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] streaming");
    doReset();
    latency = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("str_rden1",  INST_RDEN,   32'h1);
    checkOutput("str_raddr1", INST_RADDR,  32'h0);
    checkOutput("str_valid1", FETCH_VALID, 32'h0);
    tick();
    checkOutput("str_valid2", FETCH_VALID, 32'h0);
    checkOutput("str_raddr2", INST_RADDR,  32'h4);
    tick();
    checkHead("str_head0", 32'h0);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkHead("str_seq", 32'(4 * i));
    end

    $display("[TB] backpressure");
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k >= 3) checkHead("bp_hold", 32'h0);
    end
    checkOutput("bp_rden",  INST_RDEN,  32'h0);
    checkOutput("bp_raddr", INST_RADDR, 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("bp_rden_resume",  INST_RDEN,  32'h1);
    checkOutput("bp_raddr_resume", INST_RADDR, 32'h10);
    for (int i = 0; i < 6; i++) begin
      checkHead("bp_seq", 32'(4 + 4 * i));
      tick();
    end

    $display("[TB] redirect with two in flight");
    doReset();
    latency = 2;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("jmp_valid3", FETCH_VALID, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0203);
    tick();
    checkOutput("jmp_valid4", FETCH_VALID, 32'h0);
    checkOutput("jmp_rden4",  INST_RDEN,   32'h0);
    checkOutput("jmp_raddr4", INST_RADDR,  32'h200);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("jmp_valid5", FETCH_VALID, 32'h0);
    checkOutput("jmp_rden5",  INST_RDEN,   32'h1);
    checkOutput("jmp_raddr5", INST_RADDR,  32'h200);
    tick();
    checkOutput("jmp_valid6", FETCH_VALID, 32'h0);
    checkOutput("jmp_raddr6", INST_RADDR,  32'h204);
    tick();
    checkOutput("jmp_valid7", FETCH_VALID, 32'h0);
    tick();
    checkHead("jmp_head200", 32'h200);
    tick();
    checkHead("jmp_head204", 32'h204);
    tick();
    checkHead("jmp_head208", 32'h208);

    $display("[TB] memory wait");
    doReset();
    latency = 1;
    base8 = acceptsAt8;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("mw_raddr3", INST_RADDR, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("mw_rden_hold",  INST_RDEN,  32'h1);
      checkOutput("mw_raddr_hold", INST_RADDR, 32'h8);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("mw_raddr_next", INST_RADDR, 32'hC);
    tick();
    checkHead("mw_head8", 32'h8);
    tick();
    checkHead("mw_headC", 32'hC);
    checkOutput("mw_single_fetch8", 32'(acceptsAt8 - base8), 32'h1);

    $display("[TB] back-to-back redirect and wrap");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    tick();
    checkOutput("wr_rden4",  INST_RDEN,   32'h0);
    checkOutput("wr_raddr4", INST_RADDR,  32'h100);
    checkOutput("wr_valid4", FETCH_VALID, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    tick();
    checkOutput("wr_rden5",  INST_RDEN,   32'h0);
    checkOutput("wr_raddr5", INST_RADDR,  32'hFFFF_FFF8);
    checkOutput("wr_valid5", FETCH_VALID, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wr_rden6",  INST_RDEN,   32'h1);
    checkOutput("wr_raddr6", INST_RADDR,  32'hFFFF_FFF8);
    checkOutput("wr_valid6", FETCH_VALID, 32'h0);
    tick();
    checkOutput("wr_raddr7", INST_RADDR,  32'hFFFF_FFFC);
    checkOutput("wr_valid7", FETCH_VALID, 32'h0);
    tick();
    checkHead("wr_headF8", 32'hFFFF_FFF8);
    tick();
    checkHead("wr_headFC", 32'hFFFF_FFFC);
    tick();
    checkHead("wr_head0", 32'h0);

    $display("[TB] reset with full queue");
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) tick();
    checkHead("rf_full", 32'h0);
    checkOutput("rf_rden_full", INST_RDEN, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rf_valid", FETCH_VALID, 32'h0);
    checkOutput("rf_rden",  INST_RDEN,   32'h0);
    checkOutput("rf_raddr", INST_RADDR,  32'h0);
    checkOutput("rf_pc",    FETCH_PC,    32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rf_rden_rel",  INST_RDEN,   32'h1);
    checkOutput("rf_raddr_rel", INST_RADDR,  32'h0);
    checkOutput("rf_valid_rel", FETCH_VALID, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, SHALL set the fetch-queue entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 INST_RDEN  out  1  SHALL be the instruction read request, registered.
REQ-006 INST_RADDR  out  32  SHALL be the request address, registered, word-aligned.
REQ-007 MEM_WAIT  in  1  SHALL be the memory stall; a request is accepted only on an edge with INST_RDEN=1 and MEM_WAIT=0.
REQ-008 INST_RVALID / INST_RDATA  in  1 / 32  SHALL be the read response; responses return in request order, latency >=1 cycle.
REQ-009 JMP_DO / JMP_PC  in  1 / 32  SHALL be the redirect strobe and target, sampled each edge.
REQ-010 FETCH_VALID / FETCH_PC / FETCH_DATA  out  1 / 32 / 32  SHALL present the queue head to decode.
REQ-011 FETCH_READY  in  1  SHALL be the decode accept; a pop occurs on an edge with FETCH_VALID=1 and FETCH_READY=1.

Function
REQ-012 The block SHALL hold a request PC (req_pc), response PC (rsp_pc), outstanding count (0..QUEUE_DEPTH), discard count (0..QUEUE_DEPTH) and a FIFO of {pc, data}, QUEUE_DEPTH entries.
REQ-013 Credit rule: INST_RDEN SHALL be driven 1 for the next cycle only if queue_count + outstanding + (accept this edge) - (pop this edge) < QUEUE_DEPTH; the queue SHALL never overflow.
REQ-014 On request acceptance, req_pc SHALL advance by 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and outstanding SHALL increment.
REQ-015 INST_RADDR SHALL equal req_pc whenever INST_RDEN=1 and SHALL hold stable while MEM_WAIT=1.
REQ-016 On INST_RVALID with discard=0, {rsp_pc, INST_RDATA} SHALL be enqueued, rsp_pc advances by 4, outstanding decrements.
REQ-017 On INST_RVALID with discard>0, the response SHALL be dropped, discard and outstanding decrement, rsp_pc unchanged.
REQ-018 Simultaneous accept and response on one edge SHALL leave outstanding unchanged; simultaneous push and pop SHALL leave queue_count unchanged, including when full.
REQ-019 FETCH_VALID SHALL be 1 iff queue_count>0; FETCH_PC/FETCH_DATA SHALL be the head entry and stable while FETCH_VALID=1 and FETCH_READY=0.
REQ-020 Zero-cycle bypass is not permitted: an enqueued response SHALL appear on FETCH_VALID no earlier than the cycle after INST_RVALID.
REQ-021 Redirect (JMP_DO=1): queue SHALL be flushed; discard SHALL become outstanding-after-this-edge, counting a request accepted and excluding a response consumed on the same edge; req_pc and rsp_pc SHALL load JMP_PC with bits [1:0] forced to 0; INST_RDEN SHALL deassert for exactly one cycle and a pop on that edge SHALL be ignored.
REQ-022 JMP_DO asserted on consecutive edges SHALL apply each redirect; the last target wins.
REQ-023 A redirect while MEM_WAIT=1 SHALL withdraw the pending unaccepted request; no request to the stale address is issued.

Reset
REQ-024 On an edge with RST=0: INST_RDEN=0, INST_RADDR=RESET_PC, req_pc=rsp_pc=RESET_PC, outstanding=0, discard=0, queue empty, FETCH_VALID=0, FETCH_PC=0, FETCH_DATA=0.
REQ-025 Reset mid-operation SHALL abandon in-flight requests; responses arriving after release SHALL be ignored only via the bench's guarantee that memory is also reset (no discard tracking across reset).
REQ-026 The first edge after RST returns to 1 SHALL drive INST_RDEN=1, INST_RADDR=RESET_PC.

Verification
REQ-027 Streaming: depth 4, 1-cycle memory, FETCH_READY=1 -> FETCH_PC sequence 0,4,8,C... one per cycle after 3-cycle startup, no gaps.
REQ-028 Backpressure: FETCH_READY=0 for 20 cycles -> exactly 4 entries queued, outstanding 0, INST_RDEN=0, head PC 0 held stable; release resumes at PC 0x10.
REQ-029 Redirect with 2 in flight: JMP_DO, JMP_PC=0x200 -> next 2 responses dropped, first FETCH_PC=0x200, queue empty in between.
REQ-030 MEM_WAIT held 5 cycles at INST_RADDR=0x8 -> address stable, no duplicate fetch; FETCH_PC continues 0x8,0xC.
REQ-031 Wrap: RESET_PC=32'hFFFF_FFF8 -> FETCH_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-032 Reset mid-stream with queue full -> next cycle FETCH_VALID=0, INST_RDEN=0; after release INST_RADDR=RESET_PC.
